// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO pointer types and Gray helpers
// Used by both the write-pointer/full side and the read-pointer/empty side.
package fifo_pkg;

   localparam int PKG_ADDRSIZE = 4;

   typedef logic [PKG_ADDRSIZE:0] ptr_t;

   typedef enum logic {HOLD0 = 1'b0, HOLD1 = 1'b1} ostate_t;

   function automatic ptr_t bin2gray(input ptr_t bin);
      return (bin >> 1) ^ bin;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      for (int i = 0; i <= PKG_ADDRSIZE; i++) begin
         bin[i] = ^(gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray to binary conversion
// Each binary bit is the XOR of all Gray bits from the MSB down to it.
module fifo_gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/rptr_empty_fwft.sv
// rtl/rptr_empty_fwft.sv - async FIFO read pointer, empty flag and FWFT output stage
// Fetches from memory whenever a word exists and the output register is free or draining.
import fifo_pkg::*;

module rptr_empty_fwft #(
   parameter int ADDRSIZE  = 4,
   parameter int DATASIZE  = 8,
   parameter int AE_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [DATASIZE-1:0] rmem_data,
   input  logic                rready,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                rvalid,
   output logic [DATASIZE-1:0] rdata,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                ralmost_empty
);

   localparam int PW = ADDRSIZE + 1;

   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] rbinnext;
   logic [ADDRSIZE:0] rgraynext;
   logic [ADDRSIZE:0] wbin_s;
   logic [ADDRSIZE:0] level_next;
   logic              fetch;
   logic              rvalid_next;
   ostate_t           state;
   ostate_t           state_next;

   fifo_gray2bin #(.WIDTH(PW)) u_wsync_g2b (
      .gray (rq2_wptr),
      .bin  (wbin_s)
   );

   assign fetch     = ~rempty & (~rvalid | rready);
   assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, fetch};
   assign rgraynext = (rbinnext >> 1) ^ rbinnext;
   assign raddr     = rbin[ADDRSIZE-1:0];
   assign rvalid    = (state == HOLD1);

   // Level counts unfetched memory words plus the word parked in rdata.
   assign rvalid_next = (state_next == HOLD1);
   assign level_next  = (wbin_s - rbinnext) + {{ADDRSIZE{1'b0}}, rvalid_next};

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
      end else begin
         rbin   <= rbinnext;
         rptr   <= rgraynext;
         rempty <= (rgraynext == rq2_wptr);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= HOLD0;
         rdata <= '0;
      end else begin
         state <= state_next;
         if (fetch) begin
            rdata <= rmem_data;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         HOLD0:   if (fetch) state_next = HOLD1;
         HOLD1:   if (rready && !fetch) state_next = HOLD0;
         default: state_next = HOLD0;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rlevel        <= '0;
         ralmost_empty <= 1'b1;
      end else begin
         rlevel        <= level_next;
         ralmost_empty <= (level_next <= PW'(AE_THRESH));
      end
   end

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// tb/tb_rptr_empty_fwft.sv - scoreboard bench for rptr_empty_fwft
// Stimulus queues expected words; a negedge monitor pops them on every transfer.
module tb_rptr_empty_fwft;

   logic       clk;
   logic       rrst_n;
   logic [4:0] rq2_wptr;
   logic [7:0] rmem_data;
   logic       rready;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic       rvalid;
   logic [7:0] rdata;
   logic [4:0] rlevel;
   logic       ralmost_empty;

   int checks = 0;
   int errors = 0;
   int xfers  = 0;
   logic [7:0] sb[$];

   rptr_empty_fwft #(.ADDRSIZE(4), .DATASIZE(8), .AE_THRESH(2)) dut (
      .rclk          (clk),
      .rrst_n        (rrst_n),
      .rq2_wptr      (rq2_wptr),
      .rmem_data     (rmem_data),
      .rready        (rready),
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .rlevel        (rlevel),
      .ralmost_empty (ralmost_empty)
   );

   assign rmem_data = 8'hA0 + {4'h0, raddr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rrst_n && rvalid && rready) begin
         checks++;
         xfers++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underrun: got rdata=%h expected no transfer", rdata);
         end else begin
            logic [7:0] exp_w;
            exp_w = sb.pop_front();
            if (rdata !== exp_w) begin
               errors++;
               $display("FAIL sb_data: got %h expected %h", rdata, exp_w);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_words(input int start_bin, input int n);
      for (int k = 0; k < n; k++) begin
         sb.push_back(8'hA0 + 8'((start_bin + k) % 16));
      end
   endtask

   task automatic do_reset();
      rrst_n   = 1'b0;
      rready   = 1'b0;
      rq2_wptr = 5'h00;
      sb.delete();
      tick(1);
      rrst_n = 1'b1;
   endtask

   task automatic wait_xfers(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (xfers < target && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (xfers < target) begin
         errors++;
         $display("FAIL %s_timeout: got %0d transfers expected %0d", name, xfers, target);
      end
   endtask

   initial begin
      rrst_n   = 1'b1;
      rready   = 1'b0;
      rq2_wptr = 5'h00;
      #2 rrst_n = 1'b0;
      #1;
      check("rst_rempty", rempty, 1);
      check("rst_rvalid", rvalid, 0);
      check("rst_rptr", rptr, 0);
      check("rst_rlevel", rlevel, 0);
      check("rst_ae", ralmost_empty, 1);
      tick(2);
      rrst_n = 1'b1;
      tick(1);

      // single word with rready low
      push_words(0, 1);
      rq2_wptr = 5'h01;
      tick(1);
      check("t2_rempty_fall", rempty, 0);
      check("t2_rvalid_low", rvalid, 0);
      tick(1);
      check("t2_rvalid", rvalid, 1);
      check("t2_rdata", rdata, 8'hA0);
      check("t2_rptr", rptr, 5'h01);
      check("t2_rempty", rempty, 1);
      check("t2_rlevel", rlevel, 1);
      rready = 1'b1;
      xfers  = 0;
      wait_xfers("t2", 1, 5);
      check("t2_rvalid_drop", rvalid, 0);
      check("t2_rlevel0", rlevel, 0);

      // full 16-word stream
      do_reset();
      push_words(0, 16);
      xfers    = 0;
      rq2_wptr = 5'h18;
      rready   = 1'b1;
      wait_xfers("t3", 16, 19);
      tick(1);
      check("t3_rptr", rptr, 5'h18);
      check("t3_rvalid", rvalid, 0);
      check("t3_rlevel", rlevel, 0);
      check("t3_rempty", rempty, 1);

      // backpressure with 6 words pending
      do_reset();
      push_words(0, 6);
      xfers    = 0;
      rq2_wptr = 5'h05;
      tick(2);
      check("t4_rvalid", rvalid, 1);
      check("t4_rlevel", rlevel, 6);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("t4_hold_rdata", rdata, 8'hA0);
         check("t4_hold_rptr", rptr, 5'h01);
         check("t4_hold_raddr", raddr, 4'h1);
      end
      rready = 1'b1;
      wait_xfers("t4", 6, 10);

      // asynchronous reset in the middle of a stream
      do_reset();
      push_words(0, 4);
      rq2_wptr = 5'h06;
      rready   = 1'b1;
      tick(3);
      #3 rrst_n = 1'b0;
      #1;
      check("mid_rempty", rempty, 1);
      check("mid_rvalid", rvalid, 0);
      check("mid_rptr", rptr, 0);
      check("mid_rlevel", rlevel, 0);
      check("mid_ae", ralmost_empty, 1);
      check("mid_rdata", rdata, 0);
      sb.delete();
      rq2_wptr = 5'h00;
      tick(1);
      rrst_n = 1'b1;

      // wrap: advance to rbin=30, then 4 words across the wrap
      do_reset();
      push_words(0, 30);
      xfers    = 0;
      rq2_wptr = 5'h11;
      rready   = 1'b1;
      wait_xfers("t5_pre", 30, 40);
      rready = 1'b0;
      tick(1);
      check("t5_rptr_30", rptr, 5'h11);
      push_words(30, 4);
      xfers    = 0;
      rq2_wptr = 5'h03;
      tick(1);
      check("t5_rptr_a", rptr, 5'h11);
      check("t5_rempty_fall", rempty, 0);
      tick(1);
      check("t5_rptr_b", rptr, 5'h10);
      rready = 1'b1;
      tick(1);
      check("t5_rptr_c", rptr, 5'h00);
      tick(1);
      check("t5_rptr_d", rptr, 5'h01);
      tick(1);
      check("t5_rptr_e", rptr, 5'h03);
      check("t5_rempty", rempty, 1);
      wait_xfers("t5", 4, 5);

      // almost-empty threshold
      do_reset();
      push_words(0, 4);
      xfers    = 0;
      rq2_wptr = 5'h06;
      tick(2);
      check("t6_lvl4", rlevel, 4);
      check("t6_ae4", ralmost_empty, 0);
      rready = 1'b1;
      tick(1);
      rready = 1'b0;
      check("t6_lvl3", rlevel, 3);
      check("t6_ae3", ralmost_empty, 0);
      rready = 1'b1;
      tick(1);
      rready = 1'b0;
      check("t6_lvl2", rlevel, 2);
      check("t6_ae2", ralmost_empty, 1);
      rready = 1'b1;
      wait_xfers("t6", 4, 8);
      tick(2);

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
